// File: rtl/ball_ctrl_if.sv
// Ball/brick collision interface: ball state published by the controller (master),
// collision verdict returned by the brick map (slave).
interface ball_ctrl_if;
    logic [9:0] o_br_ballX;
    logic [8:0] o_br_ballY;
    logic [3:0] o_br_ball_size;
    logic [1:0] o_br_speedX;
    logic [1:0] o_br_speedY;
    logic [1:0] o_br_damage;
    logic       o_brick_req;
    logic       i_brick_ack;
    logic       i_ball_brick_collision;
    logic [1:0] i_direc_var;

    modport master (
        output o_br_ballX, o_br_ballY, o_br_ball_size, o_br_speedX, o_br_speedY,
        output o_br_damage, o_brick_req,
        input  i_brick_ack, i_ball_brick_collision, i_direc_var
    );

    modport slave (
        input  o_br_ballX, o_br_ballY, o_br_ball_size, o_br_speedX, o_br_speedY,
        input  o_br_damage, o_brick_req,
        output i_brick_ack, i_ball_brick_collision, i_direc_var
    );
endinterface

// File: rtl/ball_ctrl.sv
// Ball-motion controller: parks the ball on the paddle, advances it once per frame with
// wall/paddle bounces, asks the brick map for a collision verdict and applies it.
// Optional macro BALL_SPEEDUP_EN: every 16 brick hits raise the step by one (up to 2*STEP).
module ball_ctrl #(
    parameter int SCR_W       = 640,
    parameter int SCR_H       = 480,
    parameter int BALL_SIZE   = 4,
    parameter int STEP        = 2,
    parameter int PADDLE_Y    = 448,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              game_start,
    input  logic [9:0]        paddle_x,
    input  logic [7:0]        paddle_w,
    ball_ctrl_if.master       br,
    output logic              ball_death
);
    localparam int CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic signed [11:0] Bs   = 12'(BALL_SIZE);
    localparam logic signed [11:0] XMax = 12'(SCR_W - 1);
    localparam logic signed [11:0] YMax = 12'(SCR_H - 1);
    localparam logic signed [11:0] PadY = 12'(PADDLE_Y);
    localparam logic [8:0] ParkY = 9'(PADDLE_Y - BALL_SIZE - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {StPark, StMove, StReq, StApply, StDead} state_e;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic [1:0]      sx_q, sx_d, sy_q, sy_d;
    logic            req_q, req_d;
    logic            death_q, death_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            coll_q, coll_d;
    logic [1:0]      direc_q, direc_d;

    logic [9:0]         park_x;
    logic signed [11:0] nx, ny, pad_l, pad_r, step_eff;
    logic               lost;

    // Signed per-axis displacement for the 2-bit direction code.
    function automatic logic signed [11:0] dir_step(input logic [1:0] s,
                                                    input logic signed [11:0] st);
        case (s)
            2'b01:   dir_step = st;
            2'b11:   dir_step = -st;
            default: dir_step = '0;
        endcase
    endfunction

    // 01 <-> 11; 00 (and the unused 10) are left alone.
    function automatic logic [1:0] negate(input logic [1:0] s);
        case (s)
            2'b01:   negate = 2'b11;
            2'b11:   negate = 2'b01;
            default: negate = s;
        endcase
    endfunction

    assign park_x = paddle_x + 10'(paddle_w >> 1);
    assign pad_l  = $signed({2'b00, paddle_x});
    assign pad_r  = pad_l + $signed({4'b0000, paddle_w});

`ifdef BALL_SPEEDUP_EN
    localparam logic signed [11:0] StepMax = 12'(2 * STEP);
    logic signed [11:0] step_q, step_d;
    logic [3:0]         hits_q, hits_d;
    assign step_eff = step_q;

    // Hit counter and current step; both return to base in PARK.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 12'(STEP);
            hits_q <= '0;
        end else begin
            step_q <= step_d;
            hits_q <= hits_d;
        end
    end
`else
    assign step_eff = 12'(STEP);
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StPark;
            x_q     <= park_x;
            y_q     <= ParkY;
            sx_q    <= 2'b01;
            sy_q    <= 2'b11;
            req_q   <= 1'b0;
            death_q <= 1'b0;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
            direc_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            req_q   <= req_d;
            death_q <= death_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            direc_q <= direc_d;
        end
    end

    // Next-state, motion update and handshake control.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        req_d   = 1'b0;
        death_d = 1'b0;
        cnt_d   = cnt_q;
        coll_d  = coll_q;
        direc_d = direc_q;
        lost    = 1'b0;
        nx      = $signed({2'b00, x_q}) + dir_step(sx_q, step_eff);
        ny      = $signed({3'b000, y_q}) + dir_step(sy_q, step_eff);
`ifdef BALL_SPEEDUP_EN
        step_d  = step_q;
        hits_d  = hits_q;
`endif
        unique case (state_q)
            StPark: begin
                x_d = park_x;
                y_d = ParkY;
`ifdef BALL_SPEEDUP_EN
                step_d = 12'(STEP);
                hits_d = '0;
`endif
                if (frame_tick && game_start) begin
                    sx_d    = 2'b01;
                    sy_d    = 2'b11;
                    state_d = StMove;
                end
            end
            StMove: begin
                if (frame_tick) begin
                    // X and Y are corrected independently so a corner flips both axes.
                    if (nx - Bs < 0) begin
                        x_d  = 10'(BALL_SIZE);
                        sx_d = 2'b01;
                    end else if (nx + Bs > XMax) begin
                        x_d  = 10'(SCR_W - 1 - BALL_SIZE);
                        sx_d = 2'b11;
                    end else begin
                        x_d = nx[9:0];
                    end
                    if (ny - Bs < 0) begin
                        y_d  = 9'(BALL_SIZE);
                        sy_d = 2'b01;
                    end else if (sy_q == 2'b01 && ny + Bs >= PadY && nx >= pad_l
                                 && nx <= pad_r) begin
                        y_d  = ParkY;
                        sy_d = 2'b11;
                    end else begin
                        y_d  = ny[8:0];
                        lost = (ny + Bs >= YMax);
                    end
                    if (lost) begin
                        state_d = StDead;
                        death_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            StReq: begin
                if (br.i_brick_ack) begin
                    coll_d  = br.i_ball_brick_collision;
                    direc_d = br.i_direc_var;
                    state_d = StApply;
                end else if (cnt_q == CntLast) begin
                    // Abandon the request and carry on as if nothing was hit.
                    coll_d  = 1'b0;
                    state_d = StMove;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    req_d = 1'b1;
                end
            end
            StApply: begin
                if (coll_q) begin
                    if (direc_q[0]) sx_d = negate(sx_q);
                    if (direc_q[1]) sy_d = negate(sy_q);
`ifdef BALL_SPEEDUP_EN
                    hits_d = hits_q + 4'd1;
                    if (hits_q == 4'd15 && step_q < StepMax) step_d = step_q + 12'sd1;
`endif
                end
                state_d = StMove;
            end
            StDead: state_d = StPark;
            default: state_d = StPark;
        endcase
    end

    assign br.o_br_ballX     = x_q;
    assign br.o_br_ballY     = y_q;
    assign br.o_br_ball_size = 4'(BALL_SIZE);
    assign br.o_br_speedX    = sx_q;
    assign br.o_br_speedY    = sy_q;
    assign br.o_br_damage    = 2'b01;
    assign br.o_brick_req    = req_q;
    assign ball_death        = death_q;
endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed frames push the expected published ball state into a
// queue; a monitor pops it on every request rise / death pulse and compares.
module tb_ball_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       game_start;
    logic [9:0] paddle_x;
    logic [7:0] paddle_w;
    logic       ball_death;

    ball_ctrl_if bif ();

    ball_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .game_start (game_start),
        .paddle_x   (paddle_x),
        .paddle_w   (paddle_w),
        .br         (bif),
        .ball_death (ball_death)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit death;
        int x;
        int y;
        int sx;
        int sy;
        int len;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit d, input int ex, input int ey, input int esx, input int esy,
                        input int elen);
        exp_t e;
        e.death = d;
        e.x     = ex;
        e.y     = ey;
        e.sx    = esx;
        e.sy    = esy;
        e.len   = elen;
        q.push_back(e);
    endtask

    // One frame: expected request contents, tick, then brick-side answer after dly req
    // cycles (dly = 0 means never answer and wait for the timeout).
    task automatic frame(input int ex, input int ey, input int esx, input int esy,
                         input int elen, input int dly, input bit coll_v,
                         input logic [1:0] dv_v);
        int n;
        push(1'b0, ex, ey, esx, esy, elen);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 0;
        while (bif.o_brick_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            nvec++;
            nerr++;
            $display("FAIL req_wait: req never rose, expected 1");
        end
        if (dly == 0) begin
            n = 0;
            while (bif.o_brick_req === 1'b1 && n < 200) begin
                step();
                n++;
            end
            if (n == 200) begin
                nvec++;
                nerr++;
                $display("FAIL req_timeout: req still 1 after 200 cycles, expected 0");
            end
            step();
        end else begin
            repeat (dly - 1) step();
            bif.i_brick_ack            = 1'b1;
            bif.i_ball_brick_collision = coll_v;
            bif.i_direc_var            = dv_v;
            step();
            bif.i_brick_ack            = 1'b0;
            bif.i_ball_brick_collision = 1'b0;
            bif.i_direc_var            = 2'b00;
            repeat (2) step();
        end
    endtask

    // Monitor: request rise and death pulse are the DUT's output events.
    initial begin
        exp_t cur, dcur;
        bit   rp, dp;
        int   len, dlen;
        rp = 1'b0;
        dp = 1'b0;
        len = 0;
        dlen = 0;
        cur.len = 0;
        forever begin
            @(negedge clk);
            if (bif.o_brick_req === 1'b1) begin
                if (!rp) begin
                    if (q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL req_unexpected: req rose with no expected entry");
                        cur.len = 1;
                    end else begin
                        cur = q.pop_front();
                        chk("req_event_kind", 0, int'(cur.death));
                        chk("ballX", int'(bif.o_br_ballX), cur.x);
                        chk("ballY", int'(bif.o_br_ballY), cur.y);
                        chk("speedX", int'(bif.o_br_speedX), cur.sx);
                        chk("speedY", int'(bif.o_br_speedY), cur.sy);
                    end
                    len = 1;
                end else begin
                    len++;
                end
            end else if (rp) begin
                chk("req_len", len, cur.len);
            end
            if (ball_death === 1'b1) begin
                if (!dp) begin
                    if (q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL death_unexpected: death with no expected entry");
                    end else begin
                        dcur = q.pop_front();
                        chk("death_event_kind", 1, int'(dcur.death));
                    end
                    dlen = 1;
                end else begin
                    dlen++;
                end
            end else if (dp) begin
                chk("death_len", dlen, 1);
            end
            rp = (bif.o_brick_req === 1'b1);
            dp = (ball_death === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                        = 1'b1;
        frame_tick                 = 1'b0;
        game_start                 = 1'b0;
        paddle_x                   = 10'd300;
        paddle_w                   = 8'd40;
        bif.i_brick_ack            = 1'b0;
        bif.i_ball_brick_collision = 1'b0;
        bif.i_direc_var            = 2'b00;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset / parked state
        chk("rst_ballX", int'(bif.o_br_ballX), 320);
        chk("rst_ballY", int'(bif.o_br_ballY), 443);
        chk("rst_req", int'(bif.o_brick_req), 0);
        chk("rst_speedX", int'(bif.o_br_speedX), 1);
        chk("rst_speedY", int'(bif.o_br_speedY), 3);
        chk("rst_damage", int'(bif.o_br_damage), 1);
        chk("ball_size", int'(bif.o_br_ball_size), 4);
        chk("rst_death", int'(ball_death), 0);
        paddle_x = 10'd100;
        step();
        chk("park_track", int'(bif.o_br_ballX), 120);
        paddle_x = 10'd300;
        step();
        chk("park_track_back", int'(bif.o_br_ballX), 320);

        // Launch, then frames with various brick answers
        game_start = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        frame(322, 441, 1, 3, 2, 2, 1'b0, 2'b00);
        frame(324, 439, 1, 3, 1, 1, 1'b1, 2'b10);
        frame(326, 441, 1, 1, 1, 1, 1'b1, 2'b11);
        frame(324, 439, 3, 3, 1, 1, 1'b0, 2'b11);
        frame(322, 437, 3, 3, 1, 1, 1'b0, 2'b00);

        // Reset while the request is pending; a late ack must be ignored in PARK
        push(1'b0, 320, 435, 3, 3, 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_req", int'(bif.o_brick_req), 0);
        chk("midrst_ballX", int'(bif.o_br_ballX), 320);
        chk("midrst_ballY", int'(bif.o_br_ballY), 443);
        chk("midrst_speedX", int'(bif.o_br_speedX), 1);
        chk("midrst_speedY", int'(bif.o_br_speedY), 3);
        bif.i_brick_ack            = 1'b1;
        bif.i_ball_brick_collision = 1'b1;
        bif.i_direc_var            = 2'b11;
        step();
        bif.i_brick_ack            = 1'b0;
        bif.i_ball_brick_collision = 1'b0;
        bif.i_direc_var            = 2'b00;
        step();
        chk("late_ack_req", int'(bif.o_brick_req), 0);
        chk("late_ack_speedX", int'(bif.o_br_speedX), 1);
        chk("late_ack_speedY", int'(bif.o_br_speedY), 3);

        // Diagonal run into the top-right corner, then down past the paddle to death
        paddle_x = 10'd176;
        repeat (2) step();
        chk("park_corner_x", int'(bif.o_br_ballX), 196);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        paddle_x = 10'd500;
        for (int k = 1; k <= 219; k++) frame(196 + 2 * k, 443 - 2 * k, 1, 3, 1, 1, 1'b0, 2'b00);
        frame(635, 4, 3, 1, 1, 1, 1'b0, 2'b00);
        for (int j = 1; j <= 235; j++) frame(635 - 2 * j, 4 + 2 * j, 3, 1, 1, 1, 1'b0, 2'b00);
        push(1'b1, 0, 0, 0, 0, 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
        chk("dead_park_x", int'(bif.o_br_ballX), 520);
        chk("dead_park_y", int'(bif.o_br_ballY), 443);
        chk("dead_park_req", int'(bif.o_brick_req), 0);

        // Ack timeout, next frame still moves; then 16 hits
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        frame(522, 441, 1, 3, 64, 0, 1'b0, 2'b00);
        frame(524, 439, 1, 3, 1, 1, 1'b0, 2'b00);
        for (int i = 1; i <= 16; i++) frame(524 + 2 * i, 439 - 2 * i, 1, 3, 1, 1, 1'b1, 2'b00);
`ifdef BALL_SPEEDUP_EN
        frame(559, 404, 1, 3, 1, 1, 1'b0, 2'b00);
`else
        frame(558, 405, 1, 3, 1, 1, 1'b0, 2'b00);
`endif

        n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            nerr++;
            $display("FAIL missing_event: expected X=%0d Y=%0d death=%0d never seen", e.x, e.y,
                     e.death);
        end
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
